// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and timing helpers for the HD44780 text controller.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] SET_DDRAM     = 8'h80;
    localparam logic [7:0] SPACE         = 8'h20;

    localparam logic [6:0] ROW_BASE [4] = '{7'h00, 7'h40, 7'h14, 7'h54};

    typedef logic [2:0] state_t;
    localparam state_t ST_PWRUP    = 3'd0;
    localparam state_t ST_INIT     = 3'd1;
    localparam state_t ST_IDLE     = 3'd2;
    localparam state_t ST_SET_ADDR = 3'd3;
    localparam state_t ST_WR_DATA  = 3'd4;
    localparam state_t ST_CLEAR    = 3'd5;
    localparam state_t ST_DONE     = 3'd6;

    // ceil(t * f), never less than one cycle
    function automatic int unsigned ns_to_cycles(input longint unsigned t_ns,
                                                 input longint unsigned clk_hz);
        longint unsigned c;
        c = (t_ns * clk_hz + 64'd999_999_999) / 64'd1_000_000_000;
        return (c == 64'd0) ? 32'd1 : 32'(c);
    endfunction

    function automatic int unsigned us_to_cycles(input longint unsigned t_us,
                                                 input longint unsigned clk_hz);
        return ns_to_cycles(t_us * 64'd1000, clk_hz);
    endfunction

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return FUNC_SET_8B2L;
            3'd3:             return DISP_ON;
            3'd4:             return CLEAR;
            default:          return ENTRY_INC;
        endcase
    endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// One HD44780 bus write: setup, E pulse, hold, then the command execution wait.
module lcd_byte_xfer #(
    parameter int unsigned E_CYC   = 13,
    parameter int unsigned CMD_CYC = 1000,
    parameter int unsigned CLR_CYC = 41000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_d,
    output logic       done
);

    localparam int unsigned MAX_A   = (E_CYC > CMD_CYC) ? E_CYC : CMD_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > CLR_CYC) ? MAX_A : CLR_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] X_IDLE  = 3'd0;
    localparam logic [2:0] X_SETUP = 3'd1;
    localparam logic [2:0] X_PULSE = 3'd2;
    localparam logic [2:0] X_HOLD  = 3'd3;
    localparam logic [2:0] X_WAIT  = 3'd4;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             long_q;
    logic             done_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= X_IDLE;
            cnt    <= '0;
            long_q <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
            lcd_d  <= 8'h00;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            lcd_e <= (state_nx == X_PULSE);
            // RS/D latched at start and held through the whole transfer
            if (state == X_IDLE && start) begin
                lcd_rs <= rs;
                lcd_d  <= data;
                long_q <= long_wait;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            X_IDLE: if (start) begin
                state_nx = X_SETUP;
                cnt_nx   = CNT_W'(E_CYC - 1);
            end
            X_SETUP: if (cnt == '0) begin
                state_nx = X_PULSE;
                cnt_nx   = CNT_W'(E_CYC - 1);
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            X_PULSE: if (cnt == '0) state_nx = X_HOLD;
                     else cnt_nx = cnt - 1'b1;
            X_HOLD: begin
                state_nx = X_WAIT;
                cnt_nx   = long_q ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
            end
            X_WAIT: if (cnt == '0) begin
                state_nx = X_IDLE;
                done_nx  = 1'b1;
            end else begin
                cnt_nx = cnt - 1'b1;
            end
            default: state_nx = X_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 8-bit text controller: power-on init, then chars/clear/newline/backspace with cursor tracking.
// Define LCD_AUTOCLEAR_EN to clear the panel automatically when the cursor wraps past the last row.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned E_HIGH_NS   = 500,
    parameter int unsigned PWRUP_US    = 40_000,
    parameter int unsigned CMD_US      = 40,
    parameter int unsigned CLR_US      = 1_640,
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          char_valid,
    input  logic [7:0]    char_data,
    output logic          char_ready,
    input  logic          clear_req,
    input  logic          nl_req,
    input  logic          bs_req,
    output logic          busy,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic          lcd_rs,
    output logic          lcd_e,
    output logic [7:0]    lcd_d
);

    localparam int unsigned E_CYC   = ns_to_cycles(64'(E_HIGH_NS), 64'(CLK_FREQ_HZ));
    localparam int unsigned CMD_CYC = us_to_cycles(64'(CMD_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned CLR_CYC = us_to_cycles(64'(CLR_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned PWR_CYC = us_to_cycles(64'(PWRUP_US), 64'(CLK_FREQ_HZ));
    localparam int unsigned PW      = $clog2(PWR_CYC + 1);
`ifdef LCD_AUTOCLEAR_EN
    localparam logic AUTOCLR = 1'b1;
`else
    localparam logic AUTOCLR = 1'b0;
`endif

    state_t        state, state_nx;
    logic [PW-1:0] pwr_cnt;
    logic [2:0]    init_idx;
    logic          pend;
    logic [RW-1:0] tgt_row, tgt_row_nx, wr_row;
    logic [CW-1:0] tgt_col, tgt_col_nx, wr_col;
    logic [7:0]    wr_char;
    logic          wrap_clr;
    logic          acc_bs, acc_char;
    logic          x_start, x_rs, x_long, x_done;
    logic [7:0]    x_data;

    logic          col_last, row_last, at_origin, adv_wrap;
    logic [RW-1:0] adv_row, prev_row, next_row;
    logic [CW-1:0] adv_col, prev_col;
    logic [6:0]    addr;

    // Cursor arithmetic from the current position
    assign col_last  = (cur_col == CW'(COLS - 1));
    assign row_last  = (cur_row == RW'(ROWS - 1));
    assign at_origin = (cur_row == '0) && (cur_col == '0);
    assign next_row  = row_last ? '0 : cur_row + 1'b1;
    assign adv_col   = col_last ? '0 : cur_col + 1'b1;
    assign adv_row   = col_last ? next_row : cur_row;
    assign adv_wrap  = col_last && row_last;
    assign prev_col  = (cur_col == '0) ? CW'(COLS - 1) : cur_col - 1'b1;
    assign prev_row  = (cur_col == '0) ? cur_row - 1'b1 : cur_row;
    assign addr      = 7'(ROW_BASE[2'(wr_row)] + 7'(wr_col));

    lcd_byte_xfer #(
        .E_CYC   (E_CYC),
        .CMD_CYC (CMD_CYC),
        .CLR_CYC (CLR_CYC)
    ) u_xfer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (x_start),
        .rs        (x_rs),
        .data      (x_data),
        .long_wait (x_long),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_d     (lcd_d),
        .done      (x_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_PWRUP;
            pwr_cnt    <= PW'(PWR_CYC - 1);
            init_idx   <= 3'd0;
            pend       <= 1'b0;
            tgt_row    <= '0;
            tgt_col    <= '0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_char    <= 8'h00;
            wrap_clr   <= 1'b0;
            cur_row    <= '0;
            cur_col    <= '0;
            char_ready <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_nx;
            tgt_row    <= tgt_row_nx;
            tgt_col    <= tgt_col_nx;
            char_ready <= (state_nx == ST_IDLE);
            busy       <= (state_nx != ST_IDLE);
            if (state == ST_PWRUP && pwr_cnt != '0) pwr_cnt <= pwr_cnt - 1'b1;
            if (state == ST_INIT && x_done) init_idx <= init_idx + 3'd1;
            if (x_start) pend <= 1'b1;
            else if (x_done) pend <= 1'b0;
            if (acc_bs) begin
                wr_row   <= prev_row;
                wr_col   <= prev_col;
                wr_char  <= SPACE;
                wrap_clr <= 1'b0;
            end
            if (acc_char) begin
                wr_row   <= cur_row;
                wr_col   <= cur_col;
                wr_char  <= char_data;
                wrap_clr <= adv_wrap;
            end
            if (state_nx == ST_DONE) begin
                cur_row <= tgt_row_nx;
                cur_col <= tgt_col_nx;
            end
        end
    end

    // One transfer is launched per visit to a bus state; x_done moves on
    always_comb begin
        state_nx   = state;
        tgt_row_nx = tgt_row;
        tgt_col_nx = tgt_col;
        acc_bs     = 1'b0;
        acc_char   = 1'b0;
        x_start    = 1'b0;
        x_rs       = 1'b0;
        x_data     = 8'h00;
        x_long     = 1'b0;
        case (state)
            ST_PWRUP: if (pwr_cnt == '0) state_nx = ST_INIT;
            ST_INIT: begin
                x_start = !pend;
                x_data  = init_cmd(init_idx);
                x_long  = (init_idx == 3'd4);
                if (x_done) state_nx = (init_idx == 3'd5) ? ST_IDLE : ST_INIT;
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_nx   = ST_CLEAR;
                    tgt_row_nx = '0;
                    tgt_col_nx = '0;
                end else if (bs_req) begin
                    if (at_origin) begin
                        state_nx   = ST_DONE;
                        tgt_row_nx = cur_row;
                        tgt_col_nx = cur_col;
                    end else begin
                        acc_bs     = 1'b1;
                        state_nx   = ST_SET_ADDR;
                        tgt_row_nx = prev_row;
                        tgt_col_nx = prev_col;
                    end
                end else if (nl_req) begin
                    state_nx   = (AUTOCLR && row_last) ? ST_CLEAR : ST_DONE;
                    tgt_row_nx = next_row;
                    tgt_col_nx = '0;
                end else if (char_valid) begin
                    acc_char   = 1'b1;
                    state_nx   = ST_SET_ADDR;
                    tgt_row_nx = adv_row;
                    tgt_col_nx = adv_col;
                end
            end
            ST_SET_ADDR: begin
                x_start = !pend;
                x_data  = SET_DDRAM | {1'b0, addr};
                if (x_done) state_nx = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                x_start = !pend;
                x_rs    = 1'b1;
                x_data  = wr_char;
                if (x_done) state_nx = (AUTOCLR && wrap_clr) ? ST_CLEAR : ST_DONE;
            end
            ST_CLEAR: begin
                x_start = !pend;
                x_data  = CLEAR;
                x_long  = 1'b1;
                if (x_done) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_PWRUP;
        endcase
    end

endmodule
